// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

    localparam int UART_WIDTH       = 32;
    localparam int UART_FRAME_TICKS = 35;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FRAME
    } tx_fifo_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter handshake for the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             Baud_Clk;
    logic             Tx_Load;
    logic [WIDTH-1:0] Data_In;
    logic             Tx_start;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             tx_active;
    logic             overflow;
    logic             tx_fault;

    modport master (
        output wr_data, wr_en, Baud_Clk, Tx_Load,
        input  Data_In, Tx_start, full, empty, count, tx_active, overflow, tx_fault
    );

    modport slave (
        input  wr_data, wr_en, Baud_Clk, Tx_Load,
        output Data_In, Tx_start, full, empty, count, tx_active, overflow, tx_fault
    );

endinterface

// File: rtl/uart_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge pulse (three clocks from input edge to pulse).
module uart_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= level;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Word FIFO in front of the UART transmitter: requests a send of the head word,
// waits for Load, then paces the frame by counting baud ticks.
//
// state | meaning
// IDLE  | waiting for a buffered word
// REQ   | Tx_start high, head word on Data_In, waiting for Load
// FRAME | word accepted, counting baud ticks until the frame ends
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FRAME_TICKS = UART_FRAME_TICKS,
    parameter int REQ_TICKS   = 4
) (
    input  logic           Clock_In,
    input  logic           Reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int WIDTH = UART_WIDTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(max_int(FRAME_TICKS, REQ_TICKS) + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             full_q;
    logic             empty_q;
    logic             overflow_q;
    logic             fault_q;
    logic [WIDTH-1:0] data_q;
    logic [TW-1:0]    tick_cnt;

    tx_fifo_state_t   state;
    tx_fifo_state_t   state_next;

    logic baud_tick;
    logic load_seen;
    logic push;
    logic pop;
    logic tick_clr;
    logic load_data;
    logic fault_set;

    uart_edge_sync u_baud_sync (
        .clk   (Clock_In),
        .rst   (Reset),
        .level (bus.Baud_Clk),
        .pulse (baud_tick)
    );

    uart_edge_sync u_load_sync (
        .clk   (Clock_In),
        .rst   (Reset),
        .level (bus.Tx_Load),
        .pulse (load_seen)
    );

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = bus.wr_en && !full_q;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tick_clr   = 1'b0;
        load_data  = 1'b0;
        fault_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q) begin
                    load_data  = 1'b1;
                    tick_clr   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (load_seen) begin
                    pop        = 1'b1;
                    tick_clr   = 1'b1;
                    state_next = FRAME;
                end else if (baud_tick && tick_cnt == TW'(REQ_TICKS - 1)) begin
                    fault_set  = 1'b1;
                    state_next = IDLE;
                end
            end
            FRAME: begin
                if (baud_tick && tick_cnt == TW'(FRAME_TICKS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge Clock_In) begin
        if (Reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
            data_q     <= '0;
            tick_cnt   <= '0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            full_q  <= (count_next == CW'(DEPTH));
            empty_q <= (count_next == '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (load_data) begin
                data_q <= mem[rd_ptr];
            end
            // Saturating so a stalled frame can never alias back to a short count.
            if (tick_clr) begin
                tick_cnt <= '0;
            end else if (baud_tick && tick_cnt != '1) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign bus.Data_In   = data_q;
    assign bus.Tx_start  = (state == REQ);
    assign bus.tx_active = (state != IDLE);
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.tx_fault  = fault_q;

endmodule
